// File: rtl/om_result_drain.sv
// Output Memory drain: fetches result words and streams them out as 16-bit distance lanes.
// Optional running lane checksum output when OM_DRAIN_CHECKSUM_EN is defined.
module om_result_drain #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 128,
    parameter int LANE_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] word_count,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] OMAR,
    input  logic [DATA_W-1:0] OMDR,
    output logic [LANE_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
`ifdef OM_DRAIN_CHECKSUM_EN
    output logic [LANE_W-1:0] checksum,
`endif
    output logic              out_last
);

    localparam int LANES = DATA_W / LANE_W;
    localparam int LI_W  = $clog2(LANES);
    localparam int LB_W  = $clog2(LANE_W);
    localparam int DB_W  = $clog2(DATA_W);
    localparam logic [LI_W-1:0] LAST_LANE = LI_W'(LANES - 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SEND,
        DONE
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [DATA_W-1:0] word_reg;
    logic [LI_W-1:0]   lane;
    logic [ADDR_W-1:0] words_left;
    logic              busy_q;
    logic [DB_W-1:0]   lane_base;
    logic              last_word;
    logic              xfer;

    assign lane_base = {lane, {LB_W{1'b0}}};
    assign last_word = (words_left == ADDR_W'(1));
    assign xfer      = out_valid && out_ready;
    assign busy      = busy_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = '0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n = (word_count == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                state_n = SEND;
            end
            SEND: begin
                out_valid = 1'b1;
                out_data  = word_reg[lane_base +: LANE_W];
                out_last  = (lane == LAST_LANE) && last_word;
                if (out_ready && lane == LAST_LANE) begin
                    state_n = last_word ? DONE : FETCH;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // busy is not raised for an empty drain, so a zero-count start only pulses done
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            OMAR       <= '0;
            word_reg   <= '0;
            lane       <= '0;
            words_left <= '0;
            busy_q     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start && word_count != '0) begin
                        words_left <= word_count;
                        OMAR       <= base_addr;
                        busy_q     <= 1'b1;
                    end
                end
                FETCH: begin
                    word_reg <= OMDR;
                    lane     <= '0;
                end
                SEND: begin
                    if (out_ready) begin
                        if (lane != LAST_LANE) begin
                            lane <= lane + LI_W'(1);
                        end else if (!last_word) begin
                            words_left <= words_left - ADDR_W'(1);
                            OMAR       <= OMAR + ADDR_W'(1);
                        end
                    end
                end
                DONE: begin
                    busy_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef OM_DRAIN_CHECKSUM_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            checksum <= '0;
        end else if (state == IDLE && start) begin
            checksum <= '0;
        end else if (xfer) begin
            checksum <= checksum + out_data;
        end
    end
`endif

endmodule

// File: tb/tb_om_result_drain.sv
// Directed bench for om_result_drain: latency, backpressure, wrap, zero count,
// start-while-busy, mid-drain reset and (when enabled) the lane checksum.
module tb_om_result_drain;

    localparam int AW = 13;
    localparam int DW = 128;
    localparam int LW = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW-1:0] word_count = '0;
    logic          busy;
    logic          done;
    logic [AW-1:0] OMAR;
    logic [DW-1:0] OMDR;
    logic [LW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          out_last;
`ifdef OM_DRAIN_CHECKSUM_EN
    logic [LW-1:0] checksum;
`endif

    logic [DW-1:0] mem [0:8191];

    int n_cmp = 0;
    int n_err = 0;

    assign OMDR = mem[OMAR];

    always #5 clock = ~clock;

    om_result_drain dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .busy       (busy),
        .done       (done),
        .OMAR       (OMAR),
        .OMDR       (OMDR),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
`ifdef OM_DRAIN_CHECKSUM_EN
        .checksum   (checksum),
`endif
        .out_last   (out_last)
    );

    function automatic logic [DW-1:0] build(input int first);
        logic [DW-1:0] w;
        w = '0;
        for (int k = 0; k < 8; k++) w[k*LW +: LW] = LW'(first + k);
        return w;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start(input logic [AW-1:0] b, input logic [AW-1:0] c);
        base_addr  = b;
        word_count = c;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if ({busy, done, out_valid, out_last} !== 4'b0000 || out_data !== '0 || OMAR !== '0) begin
            n_err++;
            $display("FAIL reset_state: got b%0b d%0b v%0b l%0b data %h omar %0d want all 0",
                     busy, done, out_valid, out_last, out_data, OMAR);
        end
        reset = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_single_word();
        out_ready = 1'b1;
        pulse_start(13'd5, 13'd1);
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b1 || OMAR !== 13'd5) begin
            n_err++;
            $display("FAIL single_fetch: got v%0b b%0b omar %0d want v0 b1 omar 5",
                     out_valid, busy, OMAR);
        end
        for (int k = 0; k < 8; k++) begin
            tick();
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== LW'(k + 1) || out_last !== (k == 7)) begin
                n_err++;
                $display("FAIL single_lane%0d: got v%0b %h l%0b want v1 %h l%0b",
                         k, out_valid, out_data, out_last, LW'(k + 1), (k == 7));
            end
        end
        tick();
        n_cmp++;
        if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL single_done: got d%0b v%0b b%0b want d1 v0 b1", done, out_valid, busy);
        end
`ifdef OM_DRAIN_CHECKSUM_EN
        n_cmp++;
        if (checksum !== 16'h0024) begin
            n_err++;
            $display("FAIL checksum_seq: got %h want 0024", checksum);
        end
`endif
        tick();
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL single_idle: got d%0b b%0b want d0 b0", done, busy);
        end
    endtask

    task automatic test_backpressure();
        int  idx;
        bit  seen;
        bit  r;
        idx  = 0;
        seen = 1'b0;
        out_ready = 1'b1;
        pulse_start(13'd5, 13'd1);
        for (int c = 0; c < 60 && !seen; c++) begin
            r = (c % 4 == 0) || (c % 4 == 3);
            out_ready = r;
            if (out_valid) begin
                n_cmp++;
                if (out_data !== LW'(idx + 1) || out_last !== (idx == 7)) begin
                    n_err++;
                    $display("FAIL bp_lane: got %h l%0b want %h l%0b",
                             out_data, out_last, LW'(idx + 1), (idx == 7));
                end
                if (r) idx++;
            end
            if (done) seen = 1'b1;
            else tick();
        end
        n_cmp++;
        if (!seen || idx != 8) begin
            n_err++;
            $display("FAIL bp_count: got done %0b lanes %0d want done 1 lanes 8", seen, idx);
        end
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_wrap();
        out_ready = 1'b1;
        pulse_start(13'd8191, 13'd2);
        n_cmp++;
        if (OMAR !== 13'd8191 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL wrap_fetch0: got omar %0d v%0b want 8191 v0", OMAR, out_valid);
        end
        for (int k = 0; k < 16; k++) begin
            tick();
            if (k == 8) begin
                n_cmp++;
                if (OMAR !== 13'd0 || out_valid !== 1'b0) begin
                    n_err++;
                    $display("FAIL wrap_fetch1: got omar %0d v%0b want 0 v0", OMAR, out_valid);
                end
                tick();
            end
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== LW'((k < 8 ? 16'h1000 : 16'h2000 - 8) + k) ||
                out_last !== (k == 15)) begin
                n_err++;
                $display("FAIL wrap_lane%0d: got v%0b %h l%0b want v1 %h l%0b", k, out_valid,
                         out_data, out_last, LW'((k < 8 ? 16'h1000 : 16'h2000 - 8) + k), (k == 15));
            end
        end
        tick();
        n_cmp++;
        if (done !== 1'b1 || OMAR !== 13'd0) begin
            n_err++;
            $display("FAIL wrap_done: got d%0b omar %0d want d1 omar 0", done, OMAR);
        end
        tick();
    endtask

    task automatic test_zero_count();
        pulse_start(13'd9, 13'd0);
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL zero_done: got d%0b b%0b v%0b want d1 b0 v0", done, busy, out_valid);
        end
        tick();
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL zero_after: got d%0b b%0b v%0b want d0 b0 v0", done, busy, out_valid);
        end
    endtask

    task automatic test_busy_and_reset();
        int  idx;
        bit  seen;
        out_ready = 1'b1;
        pulse_start(13'd5, 13'd1);
        tick();
        tick();
        pulse_start(13'd0, 13'd3);
        n_cmp++;
        if (out_data !== 16'd3 || OMAR !== 13'd5 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL busy_ignore: got %h omar %0d b%0b want 0003 omar 5 b1",
                     out_data, OMAR, busy);
        end
        tick();
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, out_valid, out_last} !== 4'b0000 || out_data !== '0 || OMAR !== '0) begin
            n_err++;
            $display("FAIL reset_abort: got b%0b d%0b v%0b l%0b data %h omar %0d want all 0",
                     busy, done, out_valid, out_last, out_data, OMAR);
        end
`ifdef OM_DRAIN_CHECKSUM_EN
        n_cmp++;
        if (checksum !== '0) begin
            n_err++;
            $display("FAIL checksum_reset: got %h want 0000", checksum);
        end
`endif
        tick();
        tick();
        n_cmp++;
        if (done !== 1'b0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_hold: got d%0b v%0b want d0 v0", done, out_valid);
        end
        reset = 1'b1;
        tick();
        idx  = 0;
        seen = 1'b0;
        pulse_start(13'd5, 13'd1);
        for (int c = 0; c < 20 && !seen; c++) begin
            if (out_valid) begin
                n_cmp++;
                if (out_data !== LW'(idx + 1)) begin
                    n_err++;
                    $display("FAIL restart_lane: got %h want %h", out_data, LW'(idx + 1));
                end
                idx++;
            end
            if (done) seen = 1'b1;
            else tick();
        end
        n_cmp++;
        if (!seen || idx != 8) begin
            n_err++;
            $display("FAIL restart_count: got done %0b lanes %0d want done 1 lanes 8", seen, idx);
        end
        tick();
    endtask

`ifdef OM_DRAIN_CHECKSUM_EN
    task automatic test_checksum();
        bit seen;
        seen = 1'b0;
        out_ready = 1'b1;
        pulse_start(13'd7, 13'd1);
        for (int c = 0; c < 20 && !seen; c++) begin
            if (done) seen = 1'b1;
            else tick();
        end
        n_cmp++;
        if (!seen || checksum !== 16'hFFF8) begin
            n_err++;
            $display("FAIL checksum_ones: got done %0b sum %h want done 1 sum fff8", seen, checksum);
        end
        tick();
        tick();
        n_cmp++;
        if (checksum !== 16'hFFF8) begin
            n_err++;
            $display("FAIL checksum_hold: got %h want fff8", checksum);
        end
    endtask
`endif

    initial begin
        for (int a = 0; a < 8192; a++) mem[a] = '0;
        mem[5]    = build(1);
        mem[7]    = '1;
        mem[8191] = build(16'h1000);
        mem[0]    = build(16'h2000);
        test_reset();
        test_single_word();
        test_backpressure();
        test_wrap();
        test_zero_count();
        test_busy_and_reset();
`ifdef OM_DRAIN_CHECKSUM_EN
        test_checksum();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/om_result_drain.md
Name: om_result_drain

Overview:
- Reader on the far side of the Output Memory. It runs after the Bellman-Ford engine has written its 128-bit result words.
- Fetches a range of words through a combinational-read port (address out, data in the same cycle).
- Unpacks each word into eight 16-bit distance lanes and streams them out over a valid/ready interface to the host/dump logic.
- Owns the Output Memory read port (OMAR/OMDR) while busy.

Parameters:
- ADDR_W, 13, memory word address width
- DATA_W, 128, memory word width
- LANE_W, 16, width of one distance lane
- LANES, 8, lanes per word (DATA_W/LANE_W; fixed ratio, not independently settable)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin a drain; sampled only in IDLE
- base_addr  in  ADDR_W  first word address, latched on accepted start
- word_count  in  ADDR_W  number of words to drain, latched on accepted start
- busy  out  1  high from the cycle after an accepted start until DONE exits
- done  out  1  one-cycle pulse at end of a drain
- OMAR  out  ADDR_W  Output Memory read address
- OMDR  in  DATA_W  Output Memory read data (combinational w.r.t. OMAR)
- out_data  out  LANE_W  current distance lane
- out_valid  out  1  out_data valid
- out_ready  in  1  sink accepts out_data this cycle
- out_last  out  1  high with the final lane of the drain

Behaviour:
- Reset (reset=0, async): state=IDLE; OMAR=0, out_data=0, out_valid=0, out_last=0, busy=0, done=0; internal counters and word register cleared.
- States: IDLE, FETCH, SEND, DONE.
- IDLE:
  - start=1 and word_count!=0: latch count, OMAR<=base_addr, go FETCH.
  - start=1 and word_count==0: go DONE directly (done pulses, no stream).
- FETCH (1 cycle): word_reg<=OMDR (addressed by the current OMAR), lane<=0, go SEND.
- SEND:
  - out_valid=1; out_data=word_reg[lane*16 +: 16]. Lane 0 is bits [15:0], lane 7 is bits [127:112].
  - out_data is held stable while out_valid=1 and out_ready=0.
  - On out_valid and out_ready:
    - lane<7: lane++.
    - lane==7 with words_left>1: words_left--, OMAR<=OMAR+1, go FETCH.
    - lane==7 with words_left==1: go DONE.
- out_last=1 only in SEND when lane==7 and words_left==1.
- DONE (1 cycle): done=1, out_valid=0, go IDLE. busy drops on entry to IDLE.
- Latency: start accepted at cycle N → FETCH at N+1 → first out_valid at N+2.
- Throughput: 9 cycles per word with out_ready held high (1 fetch cycle + 8 lanes).
- Address arithmetic is modulo 2^ADDR_W: 8191+1 wraps to 0.
- start while busy is ignored; a drain is never restarted mid-stream.
- OMAR holds its last value in IDLE/DONE.
- Async reset mid-drain aborts immediately. No done pulse is produced, and the partial stream is discarded by the sink.

Optional Feature:
- Macro: OM_DRAIN_CHECKSUM_EN.
- With the macro defined:
  - Extra output port checksum [LANE_W-1:0].
  - Holds the mod-2^16 sum of every lane transferred (valid&ready) in the current drain.
  - Cleared to 0 on accepted start and on reset.
  - Final value is stable from the done pulse until the next accepted start.
- Without the macro: port and adder are absent; all other behaviour is identical.

Test Plan:
- Single word: reset, word at addr 5 = 0x0008_0007_..._0001 (lane k = k+1), start base=5 count=1, ready=1 → out_data 1..8 on cycles N+2..N+9, out_last only with 8, done at N+10.
- Backpressure: same setup, out_ready toggled 1,0,0,1,... → each lane held stable until accepted, no lane dropped or duplicated, same 8-value sequence.
- Multi-word and wrap: base=8191 count=2, words at 8191 and 0 → 16 lanes in order with OMAR 8191 then 0, one FETCH bubble between words, out_last on lane 16.
- Zero count: start with count=0 → no out_valid, done pulses once at N+1, busy low throughout.
- Start while busy / reset mid-drain: pulse start during SEND → ignored. Pull reset low after 3rd lane → all outputs 0 immediately, no done; a new start then drains correctly.
- Checksum (OM_DRAIN_CHECKSUM_EN): lanes 1..8 → checksum=36 (0x0024) at done. Lanes all 0xFFFF, count=1 → checksum=0xFFF8.
